// File: rtl/port_input_conditioner.sv
// port_input_conditioner: per-bit synchronizer, debouncer, edge pulses and clearable press latch (clock/notReset; rawInput,clearLatch in; stableOutput,risingPulse,fallingPulse,pressLatch out)
module port_input_conditioner #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clock,
  input  logic             notReset,
  input  logic [WIDTH-1:0] rawInput,
  input  logic [WIDTH-1:0] clearLatch,
  output logic [WIDTH-1:0] stableOutput,
  output logic [WIDTH-1:0] risingPulse,
  output logic [WIDTH-1:0] fallingPulse,
  output logic [WIDTH-1:0] pressLatch
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0] cnt_q [WIDTH];
  logic [CW-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] sync_bit, accept;
  logic [WIDTH-1:0] stable_q, stable_d, rise_q, rise_d, fall_q, fall_d, latch_q, latch_d;
  assign sync_bit = sync_q[SYNC_STAGES-1];
  always_comb begin
    accept = '0;
    cnt_d  = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync_bit[i] != stable_q[i]) && (cnt_q[i] == LAST);
      cnt_d[i]  = (sync_bit[i] == stable_q[i] || accept[i]) ? '0 : cnt_q[i] + 1'b1;
    end
    stable_d = stable_q ^ accept;
    rise_d   = accept & sync_bit;
    fall_d   = accept & ~sync_bit;
    latch_d  = rise_d | (latch_q & ~clearLatch);
  end
  always_ff @(posedge clock) begin
    if (!notReset) begin
      sync_q   <= '{default: '0};
      cnt_q    <= '{default: '0};
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      latch_q  <= '0;
    end else begin
      sync_q[0] <= rawInput;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      latch_q  <= latch_d;
    end
  end
  assign stableOutput = stable_q;
  assign risingPulse  = rise_q;
  assign fallingPulse = fall_q;
  assign pressLatch   = latch_q;
endmodule

// File: tb/tb_port_input_conditioner.sv
// tb_port_input_conditioner: directed scoreboard bench for port_input_conditioner
module tb_port_input_conditioner;
  logic clock = 1'b0;
  logic notReset = 1'b0;
  logic [3:0] rawInput = '0;
  logic [3:0] clearLatch = '0;
  logic [3:0] stableOutput, risingPulse, fallingPulse, pressLatch;
  typedef struct {
    string      name;
    logic [3:0] s, r, f, l;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int vectors = 0;
  int miscompares = 0;
  always #5 clock = ~clock;
  port_input_conditioner #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clock(clock),
    .notReset(notReset),
    .rawInput(rawInput),
    .clearLatch(clearLatch),
    .stableOutput(stableOutput),
    .risingPulse(risingPulse),
    .fallingPulse(fallingPulse),
    .pressLatch(pressLatch)
  );
  task automatic run(input string name, input int k, input logic n, input logic [3:0] raw, clr, s, r, f, l);
    repeat (k) begin
      @(negedge clock);
      notReset   = n;
      rawInput   = raw;
      clearLatch = clr;
      q.push_back('{name, s, r, f, l});
    end
  endtask
  always @(posedge clock) begin
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if ({stableOutput, risingPulse, fallingPulse, pressLatch} !== {e.s, e.r, e.f, e.l}) begin
        miscompares++;
        $display("FAIL %s @%0t: got s=%b r=%b f=%b l=%b, want s=%b r=%b f=%b l=%b", e.name, $time,
                 stableOutput, risingPulse, fallingPulse, pressLatch, e.s, e.r, e.f, e.l);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, vectors=%0d", vectors);
    $fatal(1);
  end
  initial begin
    run("reset",       3, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    run("idle",       20, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    run("press_wait",  5, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    run("press_edge",  1, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    run("press_hold",  4, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    run("glitch3",     3, 1, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    run("glitch3_end",10, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    run("glitch4",     4, 1, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    run("glitch4_wait",1, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    run("glitch4_rise",1, 1, 4'b0001, 4'b0000, 4'b0011, 4'b0010, 4'b0000, 4'b0011);
    run("glitch4_high",3, 1, 4'b0001, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011);
    run("glitch4_fall",1, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0011);
    run("glitch4_low", 2, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0011);
    run("clear1",      1, 1, 4'b0001, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    run("clear1_hold", 2, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    run("bounce_1",    1, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    run("bounce_0",    1, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    run("bounce_1b",   1, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    run("bounce_hold", 5, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    run("bounce_fall", 1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    run("bounce_low",  3, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    run("race_wait",   5, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    run("race_set",    1, 1, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0101);
    run("race_clear",  1, 1, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0001);
    run("clear0",      1, 1, 4'b0100, 4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    run("race_hold",   2, 1, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    run("rel2_wait",   5, 1, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    run("rel2_fall",   1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    run("rel2_low",    3, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    run("mid_count",   2, 1, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    run("mid_reset",   1, 0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    run("requal_wait", 5, 1, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    run("requal_rise", 1, 1, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 4'b0000, 4'b1010);
    run("requal_hold", 4, 1, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b1010);
    run("reset_latch", 1, 0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    run("reset_idle",  2, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    repeat (3) @(negedge clock);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/port_input_conditioner.md
Name: port_input_conditioner

Overview:
- Input-direction counterpart to the port output and display paths. It sits between raw devboard inputs (buttons, switches) and a core input port such as portEInput.
- Each bit is synchronized into the clock domain, debounced, and given one-cycle edge pulses plus a sticky press latch that software can clear.
- Replaces the direct, unsynchronized button-to-port wiring in the top-level test harnesses.

Parameters:
- WIDTH, 4, number of independent input bits.
- SYNC_STAGES, 2, flip-flop depth of the metastability synchronizer; legal range is 2 or more.
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronized value must differ from the stable value before it is accepted (10 ms at 50 MHz); legal range is 1 or more.

Ports:
- clock  input  1  single system clock, all logic on its rising edge.
- notReset  input  1  synchronous, active-low reset.
- rawInput  input  WIDTH  asynchronous, already polarity-corrected inputs (1 = pressed).
- stableOutput  output  WIDTH  debounced level per bit.
- risingPulse  output  WIDTH  one-cycle pulse when a stableOutput bit goes 0->1.
- fallingPulse  output  WIDTH  one-cycle pulse when a stableOutput bit goes 1->0.
- pressLatch  output  WIDTH  sticky bit, set by risingPulse.
- clearLatch  input  WIDTH  synchronous per-bit clear of pressLatch.

Behaviour:
- Reset: sampled only on a rising clock edge with notReset=0. It clears all synchronizer flops, counters, stableOutput, risingPulse, fallingPulse and pressLatch to 0. Reset overrides every other input.
- Synchronizer: rawInput[i] passes through SYNC_STAGES flops; the last stage is syncBit[i]. Synchronizer flops are the only place rawInput is sampled.
- Per-bit debounce counter: width is $clog2(DEBOUNCE_CYCLES+1). Bits are fully independent.
  - If syncBit[i] == stableOutput[i], the counter is set to 0.
  - Otherwise, if the counter equals DEBOUNCE_CYCLES-1: stableOutput[i] <= syncBit[i], the counter is set to 0, and the matching pulse is asserted for exactly the next cycle.
  - Otherwise the counter increments.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Glitches: any cycle with syncBit[i] == stableOutput[i] restarts the count. A glitch shorter than DEBOUNCE_CYCLES cycles produces no output change and no pulse.
- Latency: after a clean rawInput change, stableOutput changes on rising edge number SYNC_STAGES + DEBOUNCE_CYCLES, counted from the first edge that samples the new value. risingPulse/fallingPulse are high in the same cycle stableOutput first shows the new value, then return to 0 on the following edge.
- DEBOUNCE_CYCLES=1: a mismatch is accepted on the first cycle it is seen, so latency is SYNC_STAGES+1.
- Pulses: risingPulse[i] and fallingPulse[i] are never high together. Pulses on a given bit are separated by at least DEBOUNCE_CYCLES cycles.
- pressLatch[i]:
  - set on the edge where risingPulse[i] is asserted (so it rises together with stableOutput);
  - cleared on an edge with clearLatch[i]=1;
  - if set and clear happen on the same edge, set wins and the latch reads 1.
  - Otherwise it holds.
  - fallingPulse does not affect it.
- Reset mid-count: counters are discarded. stableOutput returns to 0, and a held input must re-qualify through the full SYNC_STAGES + DEBOUNCE_CYCLES latency.
- Outputs are registered; no combinational path exists from any input to any output.

Test Plan:
- Reset release: WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, rawInput=0000. Hold notReset=0 for 3 cycles, release -> all outputs 0000 and stay 0000 for 20 cycles.
- Clean press: rawInput[0] 0->1 held -> stableOutput=0001 on edge 6 after the change; risingPulse=0001 for exactly one cycle; pressLatch=0001 and holds.
- Glitch rejection: rawInput[1]=1 for 3 cycles then 0 -> stableOutput[1], risingPulse[1] and pressLatch[1] stay 0. Repeat with a 4-cycle pulse -> accepted, with a one-cycle risingPulse[1].
- Release and bounce: with stableOutput[0]=1, toggle rawInput[0] 1,0,1,0 one cycle each, then hold 0 -> one fallingPulse[0] only, on edge 6 after the final 0; pressLatch[0] remains 1.
- Latch clear race: assert clearLatch[2]=1 on the same edge as risingPulse[2] -> pressLatch[2]=1. Assert clearLatch[2] for 1 cycle later -> pressLatch[2]=0 next cycle.
- Reset mid-count and independence: drive rawInput=1010, pulse notReset low at cycle 3 of the count -> outputs 0000, then 1010 appears on edge 6 after release. Meanwhile bits 0 and 2 remain 0 throughout.
